// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants, FSM state type and byte-lane helper for the MEM stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int WB_W     = 2;
    localparam int REG_W    = 5;
    localparam int MEM_W    = 3;

    // Bit positions inside the MEM control field {memRead, memWrite, byteAcc}
    localparam int MEM_RD   = 2;
    localparam int MEM_WR   = 1;
    localparam int MEM_BYTE = 0;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    // Byte-lane write enable: one lane for byte stores, all four for word stores
    function automatic logic [3:0] lane_mask(input logic byte_acc, input logic [1:0] lane);
        lane_mask = byte_acc ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB outputs of the MEM stage as one bundle.
// Latency: n/a (wires only).
// Backpressure: stall flows from the stage (slave) back to upstream (master).
// Ports: aluResult/readData2/muxInst/WB/MEM in; stall, readDataOut, aluResultOut,
//        muxInstOut, WBOut out; misalignOut only with MEM_MISALIGN_TRAP_EN.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] readData2;
    logic [REG_W-1:0]  muxInst;
    logic [WB_W-1:0]   WB;
    logic [MEM_W-1:0]  MEM;

    logic              stall;
    logic [DATA_W-1:0] readDataOut;
    logic [DATA_W-1:0] aluResultOut;
    logic [REG_W-1:0]  muxInstOut;
    logic [WB_W-1:0]   WBOut;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              misalignOut;

    modport master (
        output aluResult, readData2, muxInst, WB, MEM,
        input  stall, readDataOut, aluResultOut, muxInstOut, WBOut, misalignOut
    );
    modport slave (
        input  aluResult, readData2, muxInst, WB, MEM,
        output stall, readDataOut, aluResultOut, muxInstOut, WBOut, misalignOut
    );
`else
    modport master (
        output aluResult, readData2, muxInst, WB, MEM,
        input  stall, readDataOut, aluResultOut, muxInstOut, WBOut
    );
    modport slave (
        input  aluResult, readData2, muxInst, WB, MEM,
        output stall, readDataOut, aluResultOut, muxInstOut, WBOut
    );
`endif

endinterface

// File: rtl/mem_stage_data_ram.sv
// data_ram: 2**ADDR_W x 32-bit data memory, async read, sync write with byte-lane enables.
// Latency: read combinational, write commits at the rising edge.
// Backpressure: none; the caller decides when we is asserted.
// Ports: clock, we, be[3:0], addr (word index), wdata, rdata.
module data_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    assign rdata = mem[addr];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage - word/byte load/store on internal RAM, feeds MEM/WB register.
// Latency: 1 edge for non-memory ops; WAIT_CYCLES+1 edges for memory accesses.
// Backpressure: stall high while an access is waiting; upstream holds EX/MEM and the PC.
// Ports: clock, reset_n, bus (mem_stage_if.slave). Optional MEM_MISALIGN_TRAP_EN adds
//        misalignOut and suppresses misaligned word accesses.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    mem_stage_if.slave  bus
);

    logic              mem_rd;
    logic              mem_wr;
    logic              byte_acc;
    logic              access;
    logic              is_load;
    logic              misalign;
    logic              complete;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] widx;
    logic [31:0]       rdata;
    logic [31:0]       wdata;
    logic [31:0]       load_val;
    logic [3:0]        be;
    logic              we;

    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] alu_q;
    logic [REG_W-1:0]  dst_q;
    logic [WB_W-1:0]   wb_q;

    assign mem_rd   = bus.MEM[MEM_RD];
    assign mem_wr   = bus.MEM[MEM_WR];
    assign byte_acc = bus.MEM[MEM_BYTE];
    assign access   = mem_rd | mem_wr;
    // Read+write together is treated as a store, so it never returns load data
    assign is_load  = mem_rd & ~mem_wr;
    assign lane     = bus.aluResult[1:0];
    // Upper address bits are dropped: addresses wrap modulo the RAM size
    assign widx     = bus.aluResult[ADDR_W+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = access & ~byte_acc & (lane != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign wdata = byte_acc ? {4{bus.readData2[7:0]}} : bus.readData2;
    assign be    = lane_mask(byte_acc, lane);
    // Writes only on the completion edge, never while reset is held
    assign we    = complete & mem_wr & ~misalign & reset_n;

    data_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clock (clock),
        .we    (we),
        .be    (be),
        .addr  (widx),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_comb begin
        load_val = '0;
        if (is_load && !misalign) begin
            load_val = byte_acc ? {24'b0, rdata[{lane, 3'b000} +: 8]} : rdata;
        end
    end

    // complete marks the cycle whose edge loads a real result into MEM/WB
    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            assign complete = 1'b1;
        end else begin : g_wait
            localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

            state_t           state;
            state_t           state_nxt;
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_nxt;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else begin
                    state <= state_nxt;
                    cnt   <= cnt_nxt;
                end
            end

            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                complete  = 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (access) begin
                            state_nxt = ST_BUSY;
                            cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            complete  = 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (cnt == '0) begin
                            complete  = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            cnt_nxt   = cnt - 1'b1;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    endgenerate

    assign bus.stall = ~complete;

    // MEM/WB register: real result on complete, otherwise a bubble (WB cleared, rest held)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q  <= '0;
            alu_q <= '0;
            dst_q <= '0;
            wb_q  <= '0;
        end else if (complete) begin
            rd_q  <= load_val;
            alu_q <= bus.aluResult;
            dst_q <= bus.muxInst;
            wb_q  <= misalign ? '0 : bus.WB;
        end else begin
            wb_q  <= '0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mis_q <= 1'b0;
        end else if (complete) begin
            mis_q <= misalign;
        end else begin
            mis_q <= 1'b0;
        end
    end

    assign bus.misalignOut = mis_q;
`endif

    assign bus.readDataOut  = rd_q;
    assign bus.aluResultOut = alu_q;
    assign bus.muxInstOut   = dst_q;
    assign bus.WBOut        = wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a zero-wait and a three-wait instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_stage;

    localparam logic [2:0] M_NONE = 3'b000;
    localparam logic [2:0] M_LW   = 3'b100;
    localparam logic [2:0] M_LB   = 3'b101;
    localparam logic [2:0] M_SW   = 3'b010;
    localparam logic [2:0] M_SB   = 3'b011;
    localparam logic [2:0] M_RW   = 3'b110;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    mem_stage_if bus0 ();
    mem_stage_if bus3 ();

    mem_stage #(.ADDR_W(10), .WAIT_CYCLES(0)) u_nowait (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    mem_stage #(.ADDR_W(10), .WAIT_CYCLES(3)) u_wait (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus3.slave)
    );

    task automatic drive0(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                          input logic [4:0] dst, input logic [1:0] wb);
        bus0.aluResult = a;
        bus0.readData2 = d;
        bus0.MEM       = m;
        bus0.muxInst   = dst;
        bus0.WB        = wb;
    endtask

    task automatic drive3(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                          input logic [4:0] dst, input logic [1:0] wb);
        bus3.aluResult = a;
        bus3.readData2 = d;
        bus3.MEM       = m;
        bus3.muxInst   = dst;
        bus3.WB        = wb;
    endtask

    task automatic edge1;
        @(posedge clock);
        #1;
    endtask

    // Runs one access on the wait-state instance; returns edges to completion,
    // cycles with stall high, and whether WBOut stayed 0 on every bubble edge.
    task automatic access3(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                           input logic [4:0] dst, input logic [1:0] wb,
                           output int edges, output int stalls, output bit bubble_ok);
        bit done;
        drive3(a, d, m, dst, wb);
        edges     = 0;
        stalls    = 0;
        bubble_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus3.stall) stalls++;
            done = !bus3.stall;
            edge1();
            edges++;
            if (done) break;
            if (bus3.WBOut !== 2'b00) bubble_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        drive0(32'h0000_0100, 32'h0, M_NONE, 5'd9, 2'b11);
        drive3(32'h0000_0200, 32'h0, M_NONE, 5'd3, 2'b01);
        edge1();
        vectors++; if (bus0.aluResultOut !== 32'h100) begin miscompares++; $display("FAIL pre_rst_alu0 got %h want %h", bus0.aluResultOut, 32'h100); end
        vectors++; if (bus3.aluResultOut !== 32'h200) begin miscompares++; $display("FAIL pre_rst_alu3 got %h want %h", bus3.aluResultOut, 32'h200); end
        #3 reset_n = 1'b0;
        #1;
        vectors++; if (bus0.aluResultOut !== 32'h0) begin miscompares++; $display("FAIL rst_alu0 got %h want 0", bus0.aluResultOut); end
        vectors++; if (bus0.WBOut !== 2'b00 || bus0.muxInstOut !== 5'd0 || bus0.readDataOut !== 32'h0) begin miscompares++; $display("FAIL rst_outs0 got wb=%b dst=%0d rd=%h want 0", bus0.WBOut, bus0.muxInstOut, bus0.readDataOut); end
        vectors++; if (bus3.aluResultOut !== 32'h0 || bus3.WBOut !== 2'b00 || bus3.muxInstOut !== 5'd0) begin miscompares++; $display("FAIL rst_outs3 got alu=%h wb=%b dst=%0d want 0", bus3.aluResultOut, bus3.WBOut, bus3.muxInstOut); end
        vectors++; if (bus0.stall !== 1'b0 || bus3.stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %b%b want 00", bus0.stall, bus3.stall); end
`ifdef MEM_MISALIGN_TRAP_EN
        vectors++; if (bus0.misalignOut !== 1'b0) begin miscompares++; $display("FAIL rst_mis got %b want 0", bus0.misalignOut); end
`endif
        drive0(32'h0000_1234, 32'h0, M_NONE, 5'd5, 2'b10);
        #2 reset_n = 1'b1;
        edge1();
        vectors++; if (bus0.aluResultOut !== 32'h1234) begin miscompares++; $display("FAIL idle_alu got %h want %h", bus0.aluResultOut, 32'h1234); end
        vectors++; if (bus0.muxInstOut !== 5'd5) begin miscompares++; $display("FAIL idle_dst got %0d want 5", bus0.muxInstOut); end
        vectors++; if (bus0.WBOut !== 2'b10) begin miscompares++; $display("FAIL idle_wb got %b want 10", bus0.WBOut); end
        vectors++; if (bus0.readDataOut !== 32'h0 || bus0.stall !== 1'b0) begin miscompares++; $display("FAIL idle_rd got rd=%h stall=%b want 0/0", bus0.readDataOut, bus0.stall); end
    endtask

    task automatic test_word;
        drive0(32'h10, 32'hDEAD_BEEF, M_SW, 5'd1, 2'b01);
        edge1();
        vectors++; if (bus0.WBOut !== 2'b01 || bus0.readDataOut !== 32'h0) begin miscompares++; $display("FAIL sw_outs got wb=%b rd=%h want 01/0", bus0.WBOut, bus0.readDataOut); end
        drive0(32'h10, 32'h0, M_LW, 5'd7, 2'b11);
        edge1();
        vectors++; if (bus0.readDataOut !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_data got %h want %h", bus0.readDataOut, 32'hDEAD_BEEF); end
        vectors++; if (bus0.WBOut !== 2'b11 || bus0.muxInstOut !== 5'd7) begin miscompares++; $display("FAIL lw_ctl got wb=%b dst=%0d want 11/7", bus0.WBOut, bus0.muxInstOut); end
        drive0(32'h55, 32'h0, M_NONE, 5'd2, 2'b10);
        edge1();
        vectors++; if (bus0.readDataOut !== 32'h0 || bus0.aluResultOut !== 32'h55) begin miscompares++; $display("FAIL nonload got rd=%h alu=%h want 0/55", bus0.readDataOut, bus0.aluResultOut); end
    endtask

    task automatic test_byte;
        drive0(32'h10, 32'h1122_3344, M_SW, 5'd1, 2'b00); edge1();
        drive0(32'h13, 32'hFFFF_FFAA, M_SB, 5'd1, 2'b00); edge1();
        drive0(32'h10, 32'h0, M_LW, 5'd3, 2'b11); edge1();
        vectors++; if (bus0.readDataOut !== 32'hAA22_3344) begin miscompares++; $display("FAIL sb_merge got %h want %h", bus0.readDataOut, 32'hAA22_3344); end
        drive0(32'h13, 32'h0, M_LB, 5'd3, 2'b11); edge1();
        vectors++; if (bus0.readDataOut !== 32'h0000_00AA) begin miscompares++; $display("FAIL lb_13 got %h want %h", bus0.readDataOut, 32'hAA); end
        drive0(32'h11, 32'h0, M_LB, 5'd3, 2'b11); edge1();
        vectors++; if (bus0.readDataOut !== 32'h0000_0033) begin miscompares++; $display("FAIL lb_11 got %h want %h", bus0.readDataOut, 32'h33); end
        drive0(32'h10, 32'h0000_0099, M_RW, 5'd3, 2'b11); edge1();
        vectors++; if (bus0.readDataOut !== 32'h0) begin miscompares++; $display("FAIL rw_rd got %h want 0", bus0.readDataOut); end
        drive0(32'h1010, 32'h0, M_LW, 5'd3, 2'b11); edge1();
        vectors++; if (bus0.readDataOut !== 32'h99) begin miscompares++; $display("FAIL wrap_rw got %h want %h", bus0.readDataOut, 32'h99); end
    endtask

    task automatic test_misalign;
`ifdef MEM_MISALIGN_TRAP_EN
        int e, s; bit b;
        drive0(32'h20, 32'h0BAD_F00D, M_SW, 5'd1, 2'b01); edge1();
        drive0(32'h22, 32'hFFFF_FFFF, M_SW, 5'd1, 2'b11); edge1();
        vectors++; if (bus0.misalignOut !== 1'b1 || bus0.WBOut !== 2'b00 || bus0.readDataOut !== 32'h0) begin miscompares++; $display("FAIL mis_sw got mis=%b wb=%b rd=%h want 1/00/0", bus0.misalignOut, bus0.WBOut, bus0.readDataOut); end
        drive0(32'h0, 32'h0, M_NONE, 5'd1, 2'b01); edge1();
        vectors++; if (bus0.misalignOut !== 1'b0 || bus0.WBOut !== 2'b01) begin miscompares++; $display("FAIL mis_clear got mis=%b wb=%b want 0/01", bus0.misalignOut, bus0.WBOut); end
        drive0(32'h20, 32'h0, M_LW, 5'd1, 2'b11); edge1();
        vectors++; if (bus0.readDataOut !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL mis_mem got %h want %h", bus0.readDataOut, 32'h0BAD_F00D); end
        drive0(32'h21, 32'h0, M_LW, 5'd1, 2'b11); edge1();
        vectors++; if (bus0.misalignOut !== 1'b1 || bus0.readDataOut !== 32'h0 || bus0.WBOut !== 2'b00) begin miscompares++; $display("FAIL mis_lw got mis=%b rd=%h wb=%b want 1/0/00", bus0.misalignOut, bus0.readDataOut, bus0.WBOut); end
        drive0(32'h22, 32'h0, M_LB, 5'd1, 2'b11); edge1();
        vectors++; if (bus0.misalignOut !== 1'b0 || bus0.readDataOut !== 32'hAD) begin miscompares++; $display("FAIL mis_lb got mis=%b rd=%h want 0/ad", bus0.misalignOut, bus0.readDataOut); end
        access3(32'h22, 32'h1, M_SW, 5'd1, 2'b11, e, s, b);
        vectors++; if (e !== 4 || bus3.misalignOut !== 1'b1) begin miscompares++; $display("FAIL mis_wait got edges=%0d mis=%b want 4/1", e, bus3.misalignOut); end
        drive3(32'h0, 32'h0, M_NONE, 5'd0, 2'b00);
`else
        drive0(32'h22, 32'hA5A5_A5A5, M_SW, 5'd1, 2'b01); edge1();
        drive0(32'h20, 32'h0, M_LW, 5'd1, 2'b11); edge1();
        vectors++; if (bus0.readDataOut !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL low_bits_ignored got %h want %h", bus0.readDataOut, 32'hA5A5_A5A5); end
`endif
    endtask

    task automatic test_wait;
        int e, s, e1, e2; bit b;
        access3(32'h40, 32'hCAFE_F00D, M_SW, 5'd1, 2'b01, e, s, b);
        vectors++; if (e !== 4 || s !== 3) begin miscompares++; $display("FAIL wsw_timing got edges=%0d stalls=%0d want 4/3", e, s); end
        vectors++; if (b !== 1'b1 || bus3.WBOut !== 2'b01) begin miscompares++; $display("FAIL wsw_wb got bubble_ok=%b wb=%b want 1/01", b, bus3.WBOut); end
        access3(32'h40, 32'h0, M_LW, 5'd4, 2'b11, e, s, b);
        vectors++; if (e !== 4 || s !== 3 || b !== 1'b1) begin miscompares++; $display("FAIL wlw_timing got edges=%0d stalls=%0d bubble_ok=%b want 4/3/1", e, s, b); end
        vectors++; if (bus3.readDataOut !== 32'hCAFE_F00D || bus3.WBOut !== 2'b11 || bus3.muxInstOut !== 5'd4) begin miscompares++; $display("FAIL wlw_data got rd=%h wb=%b dst=%0d want cafef00d/11/4", bus3.readDataOut, bus3.WBOut, bus3.muxInstOut); end
        access3(32'h40, 32'h0, M_LW, 5'd6, 2'b11, e1, s, b);
        vectors++; if (bus3.readDataOut !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL b2b_first got %h want %h", bus3.readDataOut, 32'hCAFE_F00D); end
        access3(32'h41, 32'h0, M_LB, 5'd6, 2'b11, e2, s, b);
        vectors++; if (e1 + e2 !== 8) begin miscompares++; $display("FAIL b2b_cycles got %0d want 8", e1 + e2); end
        vectors++; if (bus3.readDataOut !== 32'hF0) begin miscompares++; $display("FAIL b2b_second got %h want %h", bus3.readDataOut, 32'hF0); end
        drive3(32'h77, 32'h0, M_NONE, 5'd1, 2'b10);
        #1;
        vectors++; if (bus3.stall !== 1'b0) begin miscompares++; $display("FAIL wnon_stall got %b want 0", bus3.stall); end
        edge1();
        vectors++; if (bus3.aluResultOut !== 32'h77 || bus3.WBOut !== 2'b10 || bus3.readDataOut !== 32'h0) begin miscompares++; $display("FAIL wnon_pass got alu=%h wb=%b rd=%h want 77/10/0", bus3.aluResultOut, bus3.WBOut, bus3.readDataOut); end
    endtask

    task automatic test_reset_busy;
        int e, s; bit b;
        access3(32'h20, 32'h1234_5678, M_SW, 5'd1, 2'b01, e, s, b);
        drive3(32'h20, 32'h0000_0055, M_SW, 5'd1, 2'b01);
        #1;
        vectors++; if (bus3.stall !== 1'b1) begin miscompares++; $display("FAIL rb_stall_on got %b want 1", bus3.stall); end
        edge1();
        edge1();
        vectors++; if (bus3.stall !== 1'b1) begin miscompares++; $display("FAIL rb_busy got %b want 1", bus3.stall); end
        #2 reset_n = 1'b0;
        drive3(32'h0, 32'h0, M_NONE, 5'd0, 2'b00);
        #1;
        vectors++; if (bus3.stall !== 1'b0 || bus3.WBOut !== 2'b00 || bus3.aluResultOut !== 32'h0 || bus3.readDataOut !== 32'h0) begin miscompares++; $display("FAIL rb_reset got stall=%b wb=%b alu=%h rd=%h want 0", bus3.stall, bus3.WBOut, bus3.aluResultOut, bus3.readDataOut); end
        @(posedge clock);
        #3 reset_n = 1'b1;
        edge1();
        access3(32'h20, 32'h0, M_LW, 5'd2, 2'b11, e, s, b);
        vectors++; if (e !== 4 || bus3.readDataOut !== 32'h1234_5678) begin miscompares++; $display("FAIL rb_mem got edges=%0d rd=%h want 4/12345678", e, bus3.readDataOut); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        drive0(32'h0, 32'h0, M_NONE, 5'd0, 2'b00);
        drive3(32'h0, 32'h0, M_NONE, 5'd0, 2'b00);
        reset_n = 1'b0;
        #12 reset_n = 1'b1;
        edge1();
        test_reset();
        test_word();
        test_byte();
        test_misalign();
        test_wait();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
